// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - Requester and bus signal bundle for bus_arbiter
interface bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_done;
    logic [31:0] i_readdata;
    logic        i_response;

    logic        d_req;
    logic        d_write;
    logic        d_size;
    logic [31:0] d_writedata;
    logic [31:0] d_address;
    logic        d_done;
    logic [31:0] d_readdata;
    logic        d_response;

    logic        Hsize;
    logic        Hwrite;
    logic [31:0] Hwritedata;
    logic [31:0] Haddress;
    logic [31:0] Hreaddata;
    logic        Hresponse;
    logic        Hready;

    logic        busy;

    modport slave (
        input  i_req, i_address,
        input  d_req, d_write, d_size, d_writedata, d_address,
        input  Hreaddata, Hresponse, Hready,
        output i_done, i_readdata, i_response,
        output d_done, d_readdata, d_response,
        output Hsize, Hwrite, Hwritedata, Haddress,
        output busy
    );

    modport master (
        output i_req, i_address,
        output d_req, d_write, d_size, d_writedata, d_address,
        output Hreaddata, Hresponse, Hready,
        input  i_done, i_readdata, i_response,
        input  d_done, d_readdata, d_response,
        input  Hsize, Hwrite, Hwritedata, Haddress,
        input  busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Instruction/data bus arbiter with tie alternation and wait timeout
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         Hclock,
    input  logic         Hreset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic        last_grant;     // 0: I won the last tie, 1: D won it
    logic        last_grant_nx;
    logic        grant_i;
    logic        grant_d;
    logic        finish;
    logic        abort;
    logic        busy;

    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        size_q;
    logic        write_q;

    logic        i_done_q;
    logic        i_resp_q;
    logic [31:0] i_rdata_q;
    logic        d_done_q;
    logic        d_resp_q;
    logic [31:0] d_rdata_q;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        finish        = 1'b0;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    grant_i       = last_grant;
                    grant_d       = !last_grant;
                    last_grant_nx = !last_grant;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) begin
                    state_nx = IGRANT;
                end else if (grant_d) begin
                    state_nx = DGRANT;
                end
            end
            IGRANT, DGRANT: begin
                // A ready bus wins over a timeout reached in the same cycle
                if (bus.Hready) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Hclock) begin
        if (Hreset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            wait_cnt   <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 1'b0;
            write_q    <= 1'b0;
            i_done_q   <= 1'b0;
            i_resp_q   <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_done_q   <= 1'b0;
            d_resp_q   <= 1'b0;
            d_rdata_q  <= 32'd0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;

            if (grant_i) begin
                addr_q   <= bus.i_address;
                wdata_q  <= 32'd0;
                size_q   <= 1'b0;
                write_q  <= 1'b0;
                wait_cnt <= 8'd0;
            end else if (grant_d) begin
                addr_q   <= bus.d_address;
                wdata_q  <= bus.d_writedata;
                size_q   <= bus.d_size;
                write_q  <= bus.d_write;
                wait_cnt <= 8'd0;
            end else if (busy && !bus.Hready && !abort) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (finish || abort) begin
                if (state == IGRANT) begin
                    i_done_q  <= 1'b1;
                    i_rdata_q <= finish ? bus.Hreaddata : 32'd0;
                    i_resp_q  <= finish ? bus.Hresponse : 1'b1;
                end else begin
                    d_done_q  <= 1'b1;
                    d_rdata_q <= finish ? bus.Hreaddata : 32'd0;
                    d_resp_q  <= finish ? bus.Hresponse : 1'b1;
                end
            end
        end
    end

    assign busy           = (state != IDLE);
    assign bus.busy       = busy;
    assign bus.Haddress   = busy ? addr_q  : 32'd0;
    assign bus.Hwritedata = busy ? wdata_q : 32'd0;
    assign bus.Hsize      = busy && size_q;
    assign bus.Hwrite     = busy && write_q;

    assign bus.i_done     = i_done_q;
    assign bus.i_readdata = i_rdata_q;
    assign bus.i_response = i_resp_q;
    assign bus.d_done     = d_done_q;
    assign bus.d_readdata = d_rdata_q;
    assign bus.d_response = d_resp_q;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: BusArbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles a granted transfer waits for bus Hready before it is aborted.
REQ-002 Hclock  in  1  sole clock; all state updates on the rising edge.
REQ-003 Hreset  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch request; held high until i_done.
REQ-005 i_address  in  32  instruction-fetch address (read only).
REQ-006 i_done  out  1  one-cycle pulse: fetch transfer finished.
REQ-007 i_readdata  out  32  fetch data, valid with i_done and held until the next i_done.
REQ-008 i_response  out  1  fetch error flag, valid with i_done.
REQ-009 d_req  in  1  data request; held high until d_done.
REQ-010 d_write / d_size  in  1 / 1  data write enable and size.
REQ-011 d_writedata / d_address  in  32 / 32  data write value and address.
REQ-012 d_done / d_readdata / d_response  out  1 / 32 / 1  same semantics as the i_ outputs.
REQ-013 Hsize / Hwrite  out  1 / 1  bus size and write enable.
REQ-014 Hwritedata / Haddress  out  32 / 32  bus write data and address.
REQ-015 Hreaddata  in  32  bus read data.
REQ-016 Hresponse / Hready  in  1 / 1  bus error flag and bus transfer-complete.
REQ-017 busy  out  1  high while the state is IGRANT or DGRANT.

Function
REQ-018 The state machine SHALL have three states: IDLE, IGRANT, DGRANT.
REQ-019 In IDLE, when exactly one of i_req or d_req is high, the FSM SHALL move to that requester's GRANT state on the next edge.
REQ-020 When both are high in IDLE, the requester not named by register last_grant SHALL win, and last_grant SHALL then be set to the winner.
REQ-021 On the grant edge, the winner's address, size, write and writedata SHALL be registered, and the registered values SHALL drive the bus unchanged for the whole GRANT state.
REQ-022 Instruction grants SHALL drive Hwrite=0, Hsize=0 and Hwritedata=0.
REQ-023 In IDLE the bus outputs SHALL be Hwrite=0, Hsize=0, Hwritedata=0 and Haddress=0.
REQ-024 In a GRANT state with Hready=1, the next edge SHALL:
- capture Hreaddata and Hresponse into the owner's readdata and response registers;
- pulse the owner's done for exactly one cycle;
- return the FSM to IDLE.
REQ-025 Minimum latency from req high in IDLE to the done pulse SHALL be 2 cycles (grant edge plus completion edge).
REQ-026 The FSM SHALL always pass through IDLE for at least one cycle between consecutive transfers.
REQ-027 An 8-bit wait counter SHALL clear on the grant edge and increment on each GRANT cycle with Hready=0.
REQ-028 When the wait counter reaches TIMEOUT, the next edge SHALL abort the transfer:
- owner done=1, owner response=1, owner readdata=0;
- FSM returns to IDLE.
REQ-029 If Hready=1 in the same cycle the wait counter reaches TIMEOUT, normal completion (REQ-024) SHALL take priority over the abort.
REQ-030 If the owner drops req during a GRANT state, the transfer SHALL still complete and pulse done.
REQ-031 A req held high in the cycle after done SHALL be treated as a new request.
REQ-032 Only the owner's done SHALL pulse.
REQ-033 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-034 On an edge with Hreset=1:
- FSM SHALL go to IDLE;
- last_grant SHALL be set to I;
- the wait counter SHALL clear;
- all outputs SHALL be 0, including readdata registers and busy.
REQ-035 Reset asserted during a GRANT state SHALL abandon the transfer with no done pulse.

Verification
REQ-036 Bench: i_req=1, i_address=0x1FC00000; bus Hready=1 on the first GRANT cycle with Hreaddata=0x3C08BFD0 -> Haddress=0x1FC00000 and Hwrite=0 in cycle 1, i_done=1 with i_readdata=0x3C08BFD0 in cycle 2.
REQ-037 Bench: i_req and d_req both high after reset -> D is granted first; after d_done, I is granted; repeat the tie -> D and I alternate.
REQ-038 Bench: d_req write, d_address=0x1FD003F8, d_writedata=0x41; bus holds Hready=0 for 3 cycles -> bus outputs stay stable for 4 cycles, then d_done pulses once with d_response=Hresponse.
REQ-039 Bench: TIMEOUT=4, bus Hready stuck at 0 -> d_done=1 with d_response=1 and d_readdata=0 on the 5th edge after grant; FSM returns to IDLE.
REQ-040 Bench: Hreset pulsed during DGRANT -> no d_done, busy=0 and Haddress=0 on the next cycle; with both requests then high, D is granted first.
REQ-041 Bench: d_req dropped during the GRANT state -> transfer completes and d_done still pulses once.
